// File: rtl/online_otf_converter_pkg.sv
// Shared definitions for the online product converter: signed-digit encoding,
// controller states and the illegal-digit check.
package online_otf_converter_pkg;

    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;

    typedef enum logic [1:0] {StIdle, StSkip, StAccum, StDone} state_t;

    function automatic logic is_illegal(input logic [1:0] digit);
        return digit == 2'b11;
    endfunction

endpackage

// File: rtl/online_otf_converter_otf_step.sv
// One on-the-fly conversion step: appends a radix-2 signed digit to the Q/QM
// pair (QM = Q - 1) without any carry-propagate addition.
module online_otf_converter_otf_step
    import online_otf_converter_pkg::*;
#(
    parameter int unsigned W = 65
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   digit,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next
);

    logic [W-1:0] q_sh;
    logic [W-1:0] qm_sh;

    assign q_sh  = {q[W-2:0], 1'b0};
    assign qm_sh = {qm[W-2:0], 1'b0};

    always_comb begin
        q_next  = q_sh;
        qm_next = {qm_sh[W-1:1], 1'b1};
        case (digit)
            DIG_POS: begin
                q_next  = {q_sh[W-1:1], 1'b1};
                qm_next = q_sh;
            end
            DIG_NEG: begin
                q_next  = {qm_sh[W-1:1], 1'b1};
                qm_next = qm_sh;
            end
            // zero and the illegal code both step as d = 0
            default: ;
        endcase
    end

endmodule

// File: rtl/online_otf_converter.sv
// Converts the MSD-first signed-digit product stream into a two's-complement
// word, dropping the leading online-delay digits.
module online_otf_converter
    import online_otf_converter_pkg::*;
#(
    parameter int unsigned NDIGITS = 64,
    parameter int unsigned SKIP    = 4,
    parameter int unsigned W       = NDIGITS + 1,
    parameter int unsigned CNT_W   = $clog2(NDIGITS + SKIP + 1)
) (
    input  logic         clk,
    input  logic         asyn_reset,
    input  logic         start,
    input  logic         digit_valid,
    input  logic [1:0]   p_value,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         busy,
    output logic         digit_err
);

    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((SKIP == 0) ? 0 : SKIP - 1);
    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(NDIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(NDIGITS);

    state_t           state_q;
    logic [W-1:0]     q_q;
    logic [W-1:0]     qm_q;
    logic [CNT_W-1:0] cnt_q;
    logic             result_valid_q;
    logic             digit_err_q;
    logic [W-1:0]     q_next;
    logic [W-1:0]     qm_next;

    online_otf_converter_otf_step #(
        .W(W)
    ) u_step (
        .q      (q_q),
        .qm     (qm_q),
        .digit  (p_value),
        .q_next (q_next),
        .qm_next(qm_next)
    );

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state_q        <= StIdle;
            q_q            <= '0;
            qm_q           <= '1;
            cnt_q          <= '0;
            result_valid_q <= 1'b0;
            digit_err_q    <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (start) begin
                state_q     <= (SKIP > 0) ? StSkip : StAccum;
                q_q         <= '0;
                qm_q        <= '1;
                cnt_q       <= '0;
                digit_err_q <= 1'b0;
            end else if (digit_valid) begin
                case (state_q)
                    StSkip: begin
                        // a nonzero dropped digit means the product overflowed
                        if (p_value != DIG_ZERO) digit_err_q <= 1'b1;
                        if (cnt_q == SKIP_LAST) begin
                            cnt_q   <= '0;
                            state_q <= StAccum;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StAccum: begin
                        q_q  <= q_next;
                        qm_q <= qm_next;
                        if (is_illegal(p_value)) digit_err_q <= 1'b1;
                        if (cnt_q == ACC_LAST) begin
                            cnt_q          <= CNT_FULL;
                            state_q        <= StDone;
                            result_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign result       = q_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q == StSkip) || (state_q == StAccum);
    assign digit_err    = digit_err_q;

endmodule

// File: tb/tb_online_otf_converter.sv
// Directed bench for the online product converter with NDIGITS=4, using one
// instance without skipped digits and one that drops two leading digits.
module tb_online_otf_converter;

    localparam int W = 5;
    localparam logic [1:0] P = 2'b10;
    localparam logic [1:0] N = 2'b01;
    localparam logic [1:0] Z = 2'b00;
    localparam logic [1:0] X = 2'b11;

    typedef struct {
        logic         sel2;
        int           n;
        logic [11:0]  digs;
        logic [W-1:0] exp_res;
        logic [W-1:0] exp_qm;
        logic         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic asyn_reset = 1'b0;
    logic start = 1'b0;
    logic digit_valid = 1'b0;
    logic [1:0] p_value = 2'b00;
    logic sel = 1'b0;

    logic [W-1:0] res0, res2;
    logic rv0, rv2, busy0, busy2, err0, err2;

    int checks = 0;
    int failures = 0;
    vec_t vecs [7];

    always #5 clk = ~clk;

    online_otf_converter #(.NDIGITS(4), .SKIP(0)) u0 (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .digit_valid(digit_valid),
        .p_value(p_value), .result(res0), .result_valid(rv0), .busy(busy0), .digit_err(err0)
    );

    online_otf_converter #(.NDIGITS(4), .SKIP(2)) u2 (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .digit_valid(digit_valid),
        .p_value(p_value), .result(res2), .result_valid(rv2), .busy(busy2), .digit_err(err2)
    );

    wire [W-1:0] res_s  = sel ? res2 : res0;
    wire         rv_s   = sel ? rv2 : rv0;
    wire         busy_s = sel ? busy2 : busy0;
    wire         err_s  = sel ? err2 : err0;
    wire [W-1:0] qm_s   = sel ? u2.qm_q : u0.qm_q;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic dv, input logic [1:0] pv);
        start = s;
        digit_valid = dv;
        p_value = pv;
        @(posedge clk);
        #1;
        start = 1'b0;
        digit_valid = 1'b0;
    endtask

    function automatic logic [11:0] pk(input logic [1:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    initial begin
        vecs[0] = '{1'b0, 4, pk(P, Z, N, P, Z, Z), 5'b00111, 5'b00110, 1'b0};
        vecs[1] = '{1'b0, 4, pk(N, N, N, N, Z, Z), 5'b10001, 5'b10000, 1'b0};
        vecs[2] = '{1'b1, 6, pk(Z, P, P, P, P, P), 5'b01111, 5'b01110, 1'b1};
        vecs[3] = '{1'b1, 6, pk(Z, Z, P, P, P, P), 5'b01111, 5'b01110, 1'b0};
        vecs[4] = '{1'b0, 4, pk(P, X, N, P, Z, Z), 5'b00111, 5'b00110, 1'b1};
        vecs[5] = '{1'b0, 4, pk(P, N, P, N, Z, Z), 5'b00101, 5'b00100, 1'b0};
        vecs[6] = '{1'b0, 4, pk(Z, Z, Z, N, Z, Z), 5'b11111, 5'b11110, 1'b0};

        // reset state
        asyn_reset = 1'b1;
        cyc(1'b0, 1'b0, Z);
        cyc(1'b1, 1'b1, P);
        asyn_reset = 1'b0;
        check("rst_result", 8'(res0), 8'd0);
        check("rst_valid", 8'(rv0), 8'd0);
        check("rst_busy", 8'(busy0), 8'd0);
        check("rst_err", 8'(err0), 8'd0);
        check("rst_qm", 8'(u0.qm_q), 8'(5'b11111));
        cyc(1'b0, 1'b1, P);
        check("idle_digit_ignored", 8'(res0), 8'd0);

        for (int i = 0; i < 7; i++) begin
            sel = vecs[i].sel2;
            cyc(1'b1, 1'b0, Z);
            check($sformatf("v%0d_start_result", i), 8'(res_s), 8'd0);
            check($sformatf("v%0d_start_err", i), 8'(err_s), 8'd0);
            check($sformatf("v%0d_start_busy", i), 8'(busy_s), 8'd1);
            for (int j = 0; j < vecs[i].n; j++) begin
                cyc(1'b0, 1'b1, vecs[i].digs[2*j +: 2]);
                if (j < vecs[i].n - 1) begin
                    check($sformatf("v%0d_d%0d_valid", i, j), 8'(rv_s), 8'd0);
                    check($sformatf("v%0d_d%0d_busy", i, j), 8'(busy_s), 8'd1);
                end
            end
            check($sformatf("v%0d_valid", i), 8'(rv_s), 8'd1);
            check($sformatf("v%0d_result", i), 8'(res_s), 8'(vecs[i].exp_res));
            check($sformatf("v%0d_qm", i), 8'(qm_s), 8'(vecs[i].exp_qm));
            check($sformatf("v%0d_err", i), 8'(err_s), 8'(vecs[i].exp_err));
            check($sformatf("v%0d_busy_done", i), 8'(busy_s), 8'd0);
            cyc(1'b0, 1'b0, Z);
            check($sformatf("v%0d_valid_pulse", i), 8'(rv_s), 8'd0);
            check($sformatf("v%0d_held", i), 8'(res_s), 8'(vecs[i].exp_res));
            check($sformatf("v%0d_err_sticky", i), 8'(err_s), 8'(vecs[i].exp_err));
        end

        // gapped stream +1,_,_,0,_,-1,0
        sel = 1'b0;
        cyc(1'b1, 1'b0, Z);
        cyc(1'b0, 1'b1, P);
        cyc(1'b0, 1'b0, N);
        cyc(1'b0, 1'b0, P);
        check("gap_result", 8'(res0), 8'd1);
        check("gap_busy", 8'(busy0), 8'd1);
        cyc(1'b0, 1'b1, Z);
        cyc(1'b0, 1'b0, Z);
        cyc(1'b0, 1'b1, N);
        check("gap_no_valid", 8'(rv0), 8'd0);
        check("gap_busy2", 8'(busy0), 8'd1);
        cyc(1'b0, 1'b1, Z);
        check("gap_valid", 8'(rv0), 8'd1);
        check("gap_final", 8'(res0), 8'(5'b00110));
        cyc(1'b0, 1'b1, P);
        check("done_digit_result", 8'(res0), 8'(5'b00110));
        check("done_digit_valid", 8'(rv0), 8'd0);
        check("done_digit_busy", 8'(busy0), 8'd0);

        // abort with start; digit in the start cycle is ignored
        cyc(1'b1, 1'b0, Z);
        cyc(1'b0, 1'b1, P);
        cyc(1'b0, 1'b1, P);
        check("abort_mid", 8'(res0), 8'd3);
        cyc(1'b1, 1'b1, P);
        check("abort_clear", 8'(res0), 8'd0);
        check("abort_busy", 8'(busy0), 8'd1);
        cyc(1'b0, 1'b1, P);
        cyc(1'b0, 1'b1, Z);
        cyc(1'b0, 1'b1, Z);
        check("abort_no_early_valid", 8'(rv0), 8'd0);
        cyc(1'b0, 1'b1, Z);
        check("abort_valid", 8'(rv0), 8'd1);
        check("abort_result", 8'(res0), 8'(5'b01000));

        // reset mid-ACCUM, after an illegal digit set the error flag
        cyc(1'b1, 1'b0, Z);
        cyc(1'b0, 1'b1, P);
        cyc(1'b0, 1'b1, X);
        check("pre_rst_err", 8'(err0), 8'd1);
        asyn_reset = 1'b1;
        cyc(1'b1, 1'b1, P);
        asyn_reset = 1'b0;
        check("mid_rst_result", 8'(res0), 8'd0);
        check("mid_rst_busy", 8'(busy0), 8'd0);
        check("mid_rst_err", 8'(err0), 8'd0);
        check("mid_rst_valid", 8'(rv0), 8'd0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, P);
        check("post_rst_ignored", 8'(res0), 8'd0);
        check("post_rst_no_valid", 8'(rv0), 8'd0);
        check("post_rst_idle", 8'(busy0), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
